// File: rtl/alu_issue_stage_pkg.sv
// alu_issue_stage_pkg: shared widths, register-0 index and ALU opcode encodings
package alu_issue_stage_pkg;
   localparam int CPU_WIDTH  = 16;
   localparam int REG_ADDR_W = 3;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
   localparam logic [2:0] ADD_OP = 3'd0;
   localparam logic [2:0] SUB_OP = 3'd1;
   localparam logic [2:0] AND_OP = 3'd2;
   localparam logic [2:0] OR_OP  = 3'd3;
   localparam logic [2:0] XOR_OP = 3'd4;
   localparam logic [2:0] SLL_OP = 3'd5;
   localparam logic [2:0] SRL_OP = 3'd6;
endpackage

// File: rtl/alu_issue_stage_fwd_mux.sv
// fwd_mux: operand forwarding priority mux (r0 -> 0, EX/MEM, MEM/WB, register file)
module fwd_mux
   import alu_issue_stage_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] idx,
   input  logic [CPU_WIDTH-1:0]  rf_data,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  mem_we,
   input  logic [CPU_WIDTH-1:0]  mem_data,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic                  wb_we,
   input  logic [CPU_WIDTH-1:0]  wb_data,
   output logic [CPU_WIDTH-1:0]  data
);
   // younger EX/MEM result beats older MEM/WB result; r0 is never forwarded
   always_comb
      data = idx == REG_ZERO              ? '0 :
             mem_we && mem_rd == idx      ? mem_data :
             wb_we && wb_rd == idx        ? wb_data : rf_data;
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID->EX operand select, load-use stall, squash and overflow trap
module alu_issue_stage
   import alu_issue_stage_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   output logic                  id_ready,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_we,
   input  logic                  id_is_load,
   input  logic                  id_use_imm,
   input  logic [CPU_WIDTH-1:0]  id_imm,
   input  logic [2:0]            id_alu_op,
   input  logic [CPU_WIDTH-1:0]  rf_rdata1,
   input  logic [CPU_WIDTH-1:0]  rf_rdata2,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  mem_we,
   input  logic [CPU_WIDTH-1:0]  mem_data,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic                  wb_we,
   input  logic [CPU_WIDTH-1:0]  wb_data,
   input  logic                  flush,
   input  logic                  alu_overflow,
   output logic                  ex_valid,
   output logic [CPU_WIDTH-1:0]  ex_A,
   output logic [CPU_WIDTH-1:0]  ex_B,
   output logic [2:0]            ex_alu_op,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  ex_we,
   output logic                  ex_is_load,
   output logic                  ov_trap
);
   logic [CPU_WIDTH-1:0] fwd_a, fwd_b;
   logic hz, sq, accept;

   fwd_mux u_fwd_a (
      .idx(id_rs1), .rf_data(rf_rdata1), .mem_rd(mem_rd), .mem_we(mem_we), .mem_data(mem_data),
      .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data), .data(fwd_a)
   );
   fwd_mux u_fwd_b (
      .idx(id_rs2), .rf_data(rf_rdata2), .mem_rd(mem_rd), .mem_we(mem_we), .mem_data(mem_data),
      .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data), .data(fwd_b)
   );

   // load in EX feeding a source in ID stalls one cycle; squash discards ID and overrides the stall
   always_comb begin
      hz = id_valid && ex_valid && ex_is_load && ex_we && ex_rd != REG_ZERO &&
           (ex_rd == id_rs1 || (!id_use_imm && ex_rd == id_rs2));
      sq = flush || (ex_valid && alu_overflow);
      id_ready = sq || !hz;
      accept = id_valid && !sq && !hz;
   end

   // ID/EX latch: control bits follow accept, operands only load on accept
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid   <= 1'b0;
         ex_A       <= '0;
         ex_B       <= '0;
         ex_alu_op  <= ADD_OP;
         ex_rd      <= '0;
         ex_we      <= 1'b0;
         ex_is_load <= 1'b0;
         ov_trap    <= 1'b0;
      end else begin
         ov_trap    <= ex_valid && alu_overflow;
         ex_valid   <= accept;
         ex_we      <= accept && id_we && id_rd != REG_ZERO;
         ex_is_load <= accept && id_is_load;
         if (accept) begin
            ex_A      <= fwd_a;
            ex_B      <= id_use_imm ? id_imm : fwd_b;
            ex_alu_op <= id_alu_op;
            ex_rd     <= id_rd;
         end
      end
   end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: table-driven operand checks plus stall, flush, trap and reset sequences
module tb_alu_issue_stage;
   import alu_issue_stage_pkg::*;

   logic clk = 0, rst = 1;
   logic id_valid = 0, id_ready;
   logic [2:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0, mem_rd = 0, wb_rd = 0;
   logic id_we = 0, id_is_load = 0, id_use_imm = 0, mem_we = 0, wb_we = 0, flush = 0, alu_overflow = 0;
   logic [15:0] id_imm = 0, rf_rdata1 = 0, rf_rdata2 = 0, mem_data = 0, wb_data = 0;
   logic [2:0] id_alu_op = 0;
   logic ex_valid, ex_we, ex_is_load, ov_trap;
   logic [15:0] ex_A, ex_B;
   logic [2:0] ex_alu_op, ex_rd;
   int tests = 0, fails = 0;

   always #5 clk = ~clk;

   alu_issue_stage dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .id_use_imm(id_use_imm), .id_imm(id_imm),
      .id_alu_op(id_alu_op), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .mem_rd(mem_rd), .mem_we(mem_we),
      .mem_data(mem_data), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data), .flush(flush),
      .alu_overflow(alu_overflow), .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B), .ex_alu_op(ex_alu_op),
      .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load), .ov_trap(ov_trap)
   );

   typedef struct {
      logic v; logic [2:0] rs1, rs2, rd; logic we, ui; logic [15:0] imm; logic [2:0] op;
      logic [15:0] rf1, rf2; logic [2:0] mrd; logic mwe; logic [15:0] md;
      logic [2:0] wrd; logic wwe; logic [15:0] wd;
      logic [15:0] ea, eb; logic ev, ewe;
   } vec_t;
   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_valid = 0; id_we = 0; id_is_load = 0; id_use_imm = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
      mem_we = 0; wb_we = 0; flush = 0; alu_overflow = 0;
   endtask

   task automatic set_ins(input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                          input logic load, input logic [2:0] op);
      id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_we = 1; id_is_load = load;
      id_use_imm = 0; id_alu_op = op;
   endtask

   initial begin
      vecs[0] = '{1,1,2,3,1,0,16'h0,ADD_OP,16'h0005,16'h0007,0,0,16'h0,0,0,16'h0,16'h0005,16'h0007,1,1};
      vecs[1] = '{1,1,2,3,1,0,16'h0,ADD_OP,16'h0005,16'h0007,1,1,16'h00AA,1,1,16'h00BB,16'h00AA,16'h0007,1,1};
      vecs[2] = '{1,0,2,3,1,0,16'h0,OR_OP,16'h1234,16'h0007,0,1,16'h00AA,0,1,16'h00BB,16'h0000,16'h0007,1,1};
      vecs[3] = '{1,4,2,4,1,0,16'h0,XOR_OP,16'h1111,16'h0007,4,0,16'h00AA,4,1,16'h00BB,16'h00BB,16'h0007,1,1};
      vecs[4] = '{1,1,2,5,1,1,16'hFFF0,ADD_OP,16'h0005,16'h0007,2,1,16'h00AA,2,1,16'h00BB,16'h0005,16'hFFF0,1,1};
      vecs[5] = '{1,1,2,0,1,0,16'h0,AND_OP,16'h0005,16'h0007,0,0,16'h0,0,0,16'h0,16'h0005,16'h0007,1,0};
      vecs[6] = '{1,6,7,1,1,0,16'h0,SUB_OP,16'h0003,16'h0009,7,1,16'h00CC,6,1,16'h00DD,16'h00DD,16'h00CC,1,1};
      vecs[7] = '{1,5,6,2,1,0,16'h0,SLL_OP,16'h0021,16'h0022,3,1,16'h00AA,4,1,16'h00BB,16'h0021,16'h0022,1,1};
      vecs[8] = '{0,1,2,3,1,0,16'h0,ADD_OP,16'h0005,16'h0007,0,0,16'h0,0,0,16'h0,16'h0,16'h0,0,0};
      vecs[9] = '{1,2,3,2,0,0,16'h0,SRL_OP,16'h0008,16'h0002,0,0,16'h0,0,0,16'h0,16'h0008,16'h0002,1,0};

      // reset held two cycles then idle
      tick(); tick();
      rst = 0;
      tick();
      chk("rst ex_valid", ex_valid, 0); chk("rst ex_A", ex_A, 0); chk("rst ex_B", ex_B, 0);
      chk("rst ex_alu_op", ex_alu_op, 0); chk("rst ex_rd", ex_rd, 0); chk("rst ex_we", ex_we, 0);
      chk("rst ex_is_load", ex_is_load, 0); chk("rst ov_trap", ov_trap, 0); chk("rst id_ready", id_ready, 1);

      // operand select table
      for (int i = 0; i < 10; i++) begin
         id_valid = vecs[i].v; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; id_rd = vecs[i].rd;
         id_we = vecs[i].we; id_is_load = 0; id_use_imm = vecs[i].ui; id_imm = vecs[i].imm;
         id_alu_op = vecs[i].op; rf_rdata1 = vecs[i].rf1; rf_rdata2 = vecs[i].rf2;
         mem_rd = vecs[i].mrd; mem_we = vecs[i].mwe; mem_data = vecs[i].md;
         wb_rd = vecs[i].wrd; wb_we = vecs[i].wwe; wb_data = vecs[i].wd;
         #1 chk($sformatf("v%0d id_ready", i), id_ready, 1);
         tick();
         chk($sformatf("v%0d ex_valid", i), ex_valid, vecs[i].ev);
         chk($sformatf("v%0d ex_we", i), ex_we, vecs[i].ewe);
         if (vecs[i].v) begin
            chk($sformatf("v%0d ex_A", i), ex_A, vecs[i].ea);
            chk($sformatf("v%0d ex_B", i), ex_B, vecs[i].eb);
            chk($sformatf("v%0d ex_alu_op", i), ex_alu_op, vecs[i].op);
            chk($sformatf("v%0d ex_rd", i), ex_rd, vecs[i].rd);
         end
      end
      idle();

      // load-use: LOAD r3 then ADD r3 stalls one cycle, then issues with EX/MEM forwarding
      set_ins(0, 0, 3, 1, ADD_OP);
      tick();
      chk("lu load ex_is_load", ex_is_load, 1);
      set_ins(3, 2, 4, 0, ADD_OP); rf_rdata1 = 16'h0001; rf_rdata2 = 16'h0002;
      #1 chk("lu stall id_ready", id_ready, 0);
      tick();
      chk("lu bubble ex_valid", ex_valid, 0);
      chk("lu bubble ex_we", ex_we, 0);
      mem_rd = 3; mem_we = 1; mem_data = 16'h0042;
      #1 chk("lu retry id_ready", id_ready, 1);
      tick();
      chk("lu issue ex_valid", ex_valid, 1);
      chk("lu issue ex_A", ex_A, 16'h0042);
      chk("lu issue ex_B", ex_B, 16'h0002);
      idle();

      // load dest matches rs2 but B is immediate: no stall
      set_ins(0, 0, 5, 1, ADD_OP);
      tick();
      set_ins(1, 5, 6, 0, ADD_OP); id_use_imm = 1; id_imm = 16'h0010;
      #1 chk("imm nohz id_ready", id_ready, 1);
      tick();
      chk("imm nohz ex_valid", ex_valid, 1);
      chk("imm nohz ex_B", ex_B, 16'h0010);
      idle();

      // flush during a stall cycle
      set_ins(0, 0, 3, 1, ADD_OP);
      tick();
      set_ins(3, 0, 4, 0, ADD_OP); flush = 1;
      #1 chk("flush id_ready", id_ready, 1);
      tick();
      chk("flush ex_valid", ex_valid, 0);
      chk("flush ex_we", ex_we, 0);
      flush = 0;
      #1 chk("flush nostall id_ready", id_ready, 1);
      tick();
      chk("flush after ex_valid", ex_valid, 1);
      idle();

      // overflow: 0x7FFF+1 in EX traps one cycle and squashes ID
      set_ins(1, 2, 3, 0, ADD_OP); rf_rdata1 = 16'h7FFF; rf_rdata2 = 16'h0001;
      tick();
      chk("ov ex_A", ex_A, 16'h7FFF);
      set_ins(1, 2, 4, 0, SUB_OP); alu_overflow = 1;
      #1 chk("ov id_ready", id_ready, 1);
      tick();
      chk("ov trap pulse", ov_trap, 1);
      chk("ov squash ex_valid", ex_valid, 0);
      idle(); alu_overflow = 1;
      tick();
      chk("ov trap one cycle", ov_trap, 0);
      idle();
      tick();

      // reset mid-stall clears all state
      set_ins(0, 0, 3, 1, ADD_OP);
      tick();
      set_ins(3, 0, 4, 0, ADD_OP); rst = 1;
      tick();
      rst = 0;
      chk("rst stall ex_valid", ex_valid, 0);
      chk("rst stall ex_is_load", ex_is_load, 0);
      chk("rst stall ex_rd", ex_rd, 0);
      #1 chk("rst stall id_ready", id_ready, 1);
      tick();
      chk("rst stall issue", ex_valid, 1);
      idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
